// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// Built-in self-test sequencer for a dual-read, single-write RAM.
// The RAM is filled with pat(a) = seed + a, then read back through both
// read ports at once (port 1 ascending, port 2 descending). Each returned
// word is checked against the pattern one cycle after its read was issued.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   start, seed          run request and pattern seed, sampled in IDLE only
//   busy, done           run in progress / one-cycle end-of-run pulse
//   pass                 result of the last run, held until the next start
//   fail_addr, fail_port first mismatch: address and port (0 = port 1, 1 = port 2)
//   write_en, addr_in, data_in     RAM write port
//   read_en1, addr_out_1, data_out1 RAM read port 1
//   read_en2, addr_out_2, data_out2 RAM read port 2
//
// state   | meaning
// IDLE    | waiting for start
// WRITE   | writing pat(cnt) to address cnt
// READ    | reading cnt on port 1 and D-1-cnt on port 2, checking previous read
// DRAIN   | checking the last read, no new reads
// DONE    | done pulse, result valid

module ram_bist_ctrl #(
   parameter int BW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [BW-1:0] seed,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW-1:0] fail_addr,
   output logic          fail_port,
   output logic          write_en,
   output logic [BW-1:0] data_in,
   output logic [AW-1:0] addr_in,
   output logic          read_en1,
   output logic [AW-1:0] addr_out_1,
   input  logic [BW-1:0] data_out1,
   output logic          read_en2,
   output logic [AW-1:0] addr_out_2,
   input  logic [BW-1:0] data_out2
);

   localparam logic [AW-1:0] LAST = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] cnt, cnt_nxt;
   logic [BW-1:0] seed_r, seed_nxt;
   logic          pass_nxt;
   logic [AW-1:0] fail_addr_nxt;
   logic          fail_port_nxt;

   // addresses issued in the previous cycle, aligned with the RAM read latency
   logic [AW-1:0] exp_a1, exp_a2;

   logic          cmp_en;
   logic [BW-1:0] pat1, pat2;
   logic          mis1, mis2;

   assign cmp_en = ((state == S_READ) && (cnt != '0)) || (state == S_DRAIN);
   assign pat1   = seed_r + BW'(exp_a1);
   assign pat2   = seed_r + BW'(exp_a2);
   assign mis1   = cmp_en && (data_out1 != pat1);
   assign mis2   = cmp_en && (data_out2 != pat2);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         seed_r    <= '0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_port <= 1'b0;
         exp_a1    <= '0;
         exp_a2    <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         seed_r    <= seed_nxt;
         pass      <= pass_nxt;
         fail_addr <= fail_addr_nxt;
         fail_port <= fail_port_nxt;
         exp_a1    <= cnt;
         exp_a2    <= ~cnt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      seed_nxt      = seed_r;
      pass_nxt      = pass;
      fail_addr_nxt = fail_addr;
      fail_port_nxt = fail_port;
      busy          = 1'b0;
      done          = 1'b0;
      write_en      = 1'b0;
      addr_in       = '0;
      data_in       = '0;
      read_en1      = 1'b0;
      addr_out_1    = '0;
      read_en2      = 1'b0;
      addr_out_2    = '0;

      unique case (state)
         S_IDLE: begin
            if (start) begin
               seed_nxt      = seed;
               pass_nxt      = 1'b0;
               fail_addr_nxt = '0;
               fail_port_nxt = 1'b0;
               cnt_nxt       = '0;
               state_nxt     = S_WRITE;
            end
         end
         S_WRITE: begin
            busy     = 1'b1;
            write_en = 1'b1;
            addr_in  = cnt;
            data_in  = seed_r + BW'(cnt);
            cnt_nxt  = cnt + 1'b1;
            if (cnt == LAST) begin
               cnt_nxt   = '0;
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            busy       = 1'b1;
            read_en1   = 1'b1;
            addr_out_1 = cnt;
            read_en2   = 1'b1;
            addr_out_2 = ~cnt;
            cnt_nxt    = cnt + 1'b1;
            // port 1 wins when both ports miscompare in the same cycle
            if (mis1) begin
               fail_addr_nxt = exp_a1;
               fail_port_nxt = 1'b0;
               state_nxt     = S_DONE;
            end else if (mis2) begin
               fail_addr_nxt = exp_a2;
               fail_port_nxt = 1'b1;
               state_nxt     = S_DONE;
            end else if (cnt == LAST) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (mis1) begin
               fail_addr_nxt = exp_a1;
               fail_port_nxt = 1'b0;
            end else if (mis2) begin
               fail_addr_nxt = exp_a2;
               fail_port_nxt = 1'b1;
            end else begin
               pass_nxt = 1'b1;
            end
            state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
